// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating
// bubble counter. Every ex_* output comes straight from a flop, so nothing
// on the ID side reaches the EX side without passing through a clock edge.
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [9:0]        id_ctrl,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [9:0]        ex_ctrl,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Position of MemRead inside {RegDst,Jump,ALUsrc,MemtoReg,MemRead,MemWrite,Branch,RegWrite,ALUop[1:0]}
    localparam int MEMREAD_BIT = 5;

    logic              valid_q, valid_d;
    logic [9:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;

    // Load in EX writing a register the ID instruction reads; $0 never counts.
    // A bubble carries ctrl=0, so it can never trigger this on the next cycle.
    always_comb begin
        hazard = valid_q & ctrl_q[MEMREAD_BIT] & (rt_q != 5'd0) & id_valid &
                 ((rt_q == id_rs) | (rt_q == id_rt));
    end

    // Next-state selection: flush, then hold, then bubble insert, then load.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc4_d   = pc4_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush || (!ex_stall && hazard)) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            pc4_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            if (!flush && cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!ex_stall) begin
            valid_d = id_valid;
            ctrl_d  = id_valid ? id_ctrl : 10'd0;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = id_imm;
            pc4_d   = id_pc4;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
        end
    end

    // Pipeline state; reset clears everything, including a held instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc4_q   <= pc4_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_ctrl        = ctrl_q;
    assign ex_rd1         = rd1_q;
    assign ex_rd2         = rd2_q;
    assign ex_imm         = imm_q;
    assign ex_pc4         = pc4_q;
    assign ex_rs          = rs_q;
    assign ex_rt          = rt_q;
    assign ex_rd          = rd_q;
    assign load_use_stall = hazard;
    assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: a default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_id_ex_reg;

    localparam logic [9:0] RTYPE = 10'b1000000110;
    localparam logic [9:0] LW    = 10'b0011100100;

    logic        clk, rst;
    logic        id_valid;
    logic [9:0]  id_ctrl;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_stall, flush;

    logic        ex_valid, ex_valid2;
    logic [9:0]  ex_ctrl, ex_ctrl2;
    logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [31:0] ex_rd1_2, ex_rd2_2, ex_imm_2, ex_pc4_2;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_rs2, ex_rt2, ex_rd2_s;
    logic        lus, lus2;
    logic [15:0] bcnt;
    logic [1:0]  bcnt2;

    int checks = 0;
    int errors = 0;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .load_use_stall(lus), .bubble_cnt(bcnt)
    );

    id_ex_reg #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid2), .ex_ctrl(ex_ctrl2),
        .ex_rd1(ex_rd1_2), .ex_rd2(ex_rd2_2), .ex_imm(ex_imm_2), .ex_pc4(ex_pc4_2),
        .ex_rs(ex_rs2), .ex_rt(ex_rt2), .ex_rd(ex_rd2_s),
        .load_use_stall(lus2), .bubble_cnt(bcnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] base);
        id_valid = v;
        id_ctrl  = c;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_rd1   = base;
        id_rd2   = base + 32'd1;
        id_imm   = base + 32'd2;
        id_pc4   = base + 32'd4;
    endtask

    initial begin
        rst = 1'b1;
        ex_stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #2;
        check("reset_valid", 64'(ex_valid), 64'd0);
        check("reset_ctrl", 64'(ex_ctrl), 64'd0);
        check("reset_cnt", 64'(bcnt), 64'd0);
        check("reset_cnt_sat", 64'(bcnt2), 64'd0);
        step();
        rst = 1'b0;

        // R-type load, one cycle latency
        drive(1'b1, RTYPE, 5'd1, 5'd2, 5'd3, 32'h1000_0000);
        #1 check("rtype_no_comb_path", 64'(ex_valid), 64'd0);
        step();
        check("rtype_ctrl", 64'(ex_ctrl), 64'(RTYPE));
        check("rtype_rd", 64'(ex_rd), 64'd3);
        check("rtype_valid", 64'(ex_valid), 64'd1);
        check("rtype_rs", 64'(ex_rs), 64'd1);
        check("rtype_rd1", 64'(ex_rd1), 64'h1000_0000);
        check("rtype_pc4", 64'(ex_pc4), 64'h1000_0004);

        // Load-use: LW to $8 followed by a reader of $8
        drive(1'b1, LW, 5'd5, 5'd8, 5'd0, 32'h2000_0000);
        step();
        check("lw_rt", 64'(ex_rt), 64'd8);
        drive(1'b1, RTYPE, 5'd8, 5'd9, 5'd10, 32'h3000_0000);
        #1 check("lu_stall_high", 64'(lus), 64'd1);
        step();
        check("lu_bubble_valid", 64'(ex_valid), 64'd0);
        check("lu_bubble_ctrl", 64'(ex_ctrl), 64'd0);
        check("lu_bubble_rt", 64'(ex_rt), 64'd0);
        check("lu_bubble_imm", 64'(ex_imm), 64'd0);
        check("lu_cnt", 64'(bcnt), 64'd1);
        check("lu_stall_after_bubble", 64'(lus), 64'd0);
        step();
        check("lu_resume_valid", 64'(ex_valid), 64'd1);
        check("lu_resume_rs", 64'(ex_rs), 64'd8);

        // $0 destination never stalls
        drive(1'b1, LW, 5'd4, 5'd0, 5'd0, 32'h4000_0000);
        step();
        drive(1'b1, RTYPE, 5'd0, 5'd0, 5'd11, 32'h5000_0000);
        #1 check("r0_no_stall", 64'(lus), 64'd0);
        step();
        check("r0_load_valid", 64'(ex_valid), 64'd1);
        check("r0_load_rd", 64'(ex_rd), 64'd11);
        check("r0_cnt", 64'(bcnt), 64'd1);

        // Flush wins over a simultaneous hazard
        drive(1'b1, LW, 5'd4, 5'd8, 5'd0, 32'h6000_0000);
        step();
        drive(1'b1, RTYPE, 5'd8, 5'd2, 5'd12, 32'h7000_0000);
        flush = 1'b1;
        #1 check("flush_hazard_lus", 64'(lus), 64'd1);
        step();
        flush = 1'b0;
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_rd2", 64'(ex_rd2), 64'd0);
        check("flush_cnt", 64'(bcnt), 64'd1);

        // ex_stall for 3 edges with a pending hazard: hold, stall still visible
        drive(1'b1, LW, 5'd4, 5'd8, 5'd7, 32'h8000_0000);
        step();
        drive(1'b1, RTYPE, 5'd8, 5'd3, 5'd13, 32'h9000_0000);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_lus", 64'(lus), 64'd1);
            step();
            check("stall_hold_ctrl", 64'(ex_ctrl), 64'(LW));
            check("stall_hold_rd", 64'(ex_rd), 64'd7);
            check("stall_hold_rd1", 64'(ex_rd1), 64'h8000_0000);
            check("stall_hold_cnt", 64'(bcnt), 64'd1);
        end
        ex_stall = 1'b0;
        step();
        check("unstall_bubble_valid", 64'(ex_valid), 64'd0);
        check("unstall_cnt", 64'(bcnt), 64'd2);

        // Two more hazards: 4 total, 2-bit counter saturates at 3
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, LW, 5'd4, 5'd8, 5'd0, 32'hA000_0000);
            step();
            drive(1'b1, RTYPE, 5'd1, 5'd8, 5'd14, 32'hB000_0000);
            step();
        end
        check("cnt_four", 64'(bcnt), 64'd4);
        check("cnt_sat", 64'(bcnt2), 64'd3);

        // Invalid ID instruction loads with zero control
        drive(1'b0, RTYPE, 5'd1, 5'd2, 5'd15, 32'hC000_0000);
        step();
        check("invalid_valid", 64'(ex_valid), 64'd0);
        check("invalid_ctrl", 64'(ex_ctrl), 64'd0);
        check("invalid_rd", 64'(ex_rd), 64'd15);

        // Asynchronous reset between edges
        drive(1'b1, RTYPE, 5'd1, 5'd2, 5'd16, 32'hD000_0000);
        step();
        check("pre_rst_valid", 64'(ex_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(ex_valid), 64'd0);
        check("arst_ctrl", 64'(ex_ctrl), 64'd0);
        check("arst_rd", 64'(ex_rd), 64'd0);
        check("arst_cnt", 64'(bcnt), 64'd0);
        check("arst_cnt_sat", 64'(bcnt2), 64'd0);
        step();
        rst = 1'b0;
        drive(1'b1, RTYPE, 5'd6, 5'd7, 5'd17, 32'hE000_0000);
        step();
        check("post_rst_load_valid", 64'(ex_valid), 64'd1);
        check("post_rst_load_rd", 64'(ex_rd), 64'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Parameters
REQ-001 SHALL have parameter DATA_W, default 32, width of register-file data, sign-extended immediate and PC+4 paths.
REQ-002 SHALL have parameter CNT_W, default 16, width of the bubble counter.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_ctrl  input  10  decoded control {RegDst,Jump,ALUsrc,MemtoReg,MemRead,MemWrite,Branch,RegWrite,ALUop[1:0]} from the opcode decoder.
REQ-007 id_rd1, id_rd2, id_imm, id_pc4  input  DATA_W each  register-file reads, sign-extended immediate, PC+4.
REQ-008 id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-009 ex_stall  input  1  downstream hold request.
REQ-010 flush  input  1  branch/jump taken; discard the ID instruction.
REQ-011 ex_valid  output  1  EX stage holds a real instruction.
REQ-012 ex_ctrl  output  10  registered control, same bit order as id_ctrl.
REQ-013 ex_rd1, ex_rd2, ex_imm, ex_pc4  output  DATA_W each  registered data.
REQ-014 ex_rs, ex_rt, ex_rd  output  5 each  registered specifiers.
REQ-015 load_use_stall  output  1  combinational; freezes PC and IF/ID.
REQ-016 bubble_cnt  output  CNT_W  number of bubbles inserted.

Function
REQ-017 SHALL assert load_use_stall = ex_valid & ex_ctrl.MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
REQ-018 Each rising edge SHALL apply exactly one action, in priority order: flush, ex_stall, load_use_stall, load.
REQ-019 flush: ex_valid <= 0 and ex_ctrl <= 0; data and specifier fields <= 0.
REQ-020 ex_stall (no flush): all outputs hold their values; bubble_cnt unchanged.
REQ-021 load_use_stall (no flush, no ex_stall): bubble insert -- ex_valid <= 0, ex_ctrl <= 0, data and specifier fields <= 0; bubble_cnt increments.
REQ-022 load (none of the above): every ex_* field <= its id_* counterpart; ex_ctrl <= id_valid ? id_ctrl : 0.
REQ-023 Latency SHALL be 1 cycle from ID inputs to ex_* outputs on a load.
REQ-024 bubble_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-025 Flush during a load-use hazard SHALL take priority; bubble_cnt does not increment.
REQ-026 load_use_stall SHALL still be driven during ex_stall, because upstream must also hold.
REQ-027 A bubble (ex_valid=0) SHALL never raise load_use_stall on the following cycle, because ex_ctrl is 0.
REQ-028 The block SHALL contain no combinational path from id_* inputs to ex_* outputs.

Reset
REQ-029 While rst=1, all ex_* outputs and bubble_cnt SHALL be 0 immediately, independent of clk.
REQ-030 The first edge after rst falls SHALL perform a normal priority-ordered action.
REQ-031 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction.

Verification
REQ-032 R-type load: id_valid=1, id_ctrl=10'b1000000110, id_rs=1, id_rt=2, id_rd=3 -> next edge: ex_ctrl=10'b1000000110, ex_rd=3, ex_valid=1.
REQ-033 Load-use: EX holds LW (ex_ctrl=10'b0011100100, ex_rt=8) and ID has id_rs=8 -> load_use_stall=1 in the same cycle; next edge: ex_valid=0, ex_ctrl=0, bubble_cnt=1; following cycle: load_use_stall=0.
REQ-034 Register $0: LW with ex_rt=0 and ID id_rs=0 -> load_use_stall=0, normal load.
REQ-035 Flush plus hazard in the same cycle -> ex_valid=0, bubble_cnt unchanged; ex_stall=1 for 3 cycles -> outputs frozen for exactly 3 edges.
REQ-036 Assert rst asynchronously between edges while ex_valid=1 -> outputs 0 before the next edge; CNT_W=2 with 4 hazards -> bubble_cnt stays at 3.
